// File: rtl/rr_grant_arbiter_pkg.sv
// rr_grant_arbiter_pkg
//   Shared types and constants for the round-robin grant arbiter.
//   - arb_state_t : arbiter FSM states
//   - ARB_*       : default configuration constants
//   - onehot()    : index -> one-hot vector (wide; callers truncate to N)
package rr_grant_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_N            = 8;
   localparam int ARB_IDW          = 3;
   localparam int ARB_MAX_HOLD_DEF = 16;

   // Widest vector onehot() can produce; instances size-cast the result to N.
   localparam int ARB_IDW_MAX = 8;
   localparam int ARB_N_MAX   = 1 << ARB_IDW_MAX;

   function automatic logic [ARB_N_MAX-1:0] onehot(input logic [ARB_IDW_MAX-1:0] idx);
      logic [ARB_N_MAX-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if
//   Request/grant bundle between requesters and the arbiter.
//   req       : request vector, bit i is requester i
//   gnt       : registered one-hot grant (zero when idle)
//   gnt_id    : registered index of the holder (zero when idle)
//   gnt_valid : registered, high while a grant is active
//   hold_cnt  : registered cycles the holder has held the grant, from 0
//   modport master : requester side (drives req)
//   modport slave  : arbiter side (drives the grant outputs)
interface rr_grant_arbiter_if
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N   = ARB_N,
   parameter int IDW = ARB_IDW,
   parameter int CW  = 5
);
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic [CW-1:0]  hold_cnt;

   modport master (
      output req,
      input  gnt, gnt_id, gnt_valid, hold_cnt
   );

   modport slave (
      input  req,
      output gnt, gnt_id, gnt_valid, hold_cnt
   );
endinterface

// File: rtl/rr_grant_arbiter_rot_prio_pick.sv
// rot_prio_pick
//   Combinational rotate + fixed-priority pick.
//   req    : request vector
//   base   : rotation amount; requester 'base' gets top priority
//   winner : (first set bit of req rotated right by base) + base, mod N
//   any    : |req; when low, winner is base (encoder output 0), never X
module rot_prio_pick
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N   = ARB_N,
   parameter int IDW = ARB_IDW
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] base,
   output logic [IDW-1:0] winner,
   output logic           any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IDW-1:0] enc;

   // Shifting the doubled vector gives a rotate without a wrap-around mux.
   assign dbl = {req, req} >> base;
   assign rot = dbl[N-1:0];

   // NOTE: enc gets a default before the loop so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      enc = '0;
      // Scan from the top so the lowest set bit is the last (winning) write.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) enc = IDW'(i);
      end
   end

   // IDW-bit addition wraps modulo N because N is a power of two.
   assign winner = enc + base;
   assign any    = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Round-robin arbiter with a per-holder hold limit.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : rr_grant_arbiter_if.slave (req in; gnt, gnt_id, gnt_valid, hold_cnt out)
//   A holder keeps the grant until it drops its request or has held it for
//   MAX_HOLD cycles (0 = unlimited); priority then restarts just past it, so
//   the next grant follows back-to-back when anyone else is waiting.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int IDW      = ARB_IDW,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
   parameter int CW       = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_grant_arbiter_if.slave    bus
);

   // Last hold_cnt value a holder may reach before it must release.
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

   arb_state_t     state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] base;
   logic [IDW-1:0] winner;
   logic           any;
   logic           hold_expired;
   logic           release_now;

   assign hold_expired = (MAX_HOLD != 0) && (bus.hold_cnt == HOLD_LAST);
   assign release_now  = (state == GRANT) && (!bus.req[bus.gnt_id] || hold_expired);

   // While granting, the pick is always evaluated from just past the holder;
   // it is only acted on in the release cycle.
   assign base = (state == GRANT) ? bus.gnt_id + IDW'(1) : ptr;

   rot_prio_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req    (bus.req),
      .base   (base),
      .winner (winner),
      .any    (any)
   );

   // NOTE: all state and outputs here are updated with non-blocking
   // assignments so every read in this block sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         bus.gnt       <= '0;
         bus.gnt_id    <= '0;
         bus.gnt_valid <= 1'b0;
         bus.hold_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  state         <= GRANT;
                  bus.gnt       <= N'(onehot(ARB_IDW_MAX'(winner)));
                  bus.gnt_id    <= winner;
                  bus.gnt_valid <= 1'b1;
                  bus.hold_cnt  <= '0;
               end
            end

            GRANT: begin
               if (release_now) begin
                  ptr <= base;
                  if (any) begin
                     bus.gnt      <= N'(onehot(ARB_IDW_MAX'(winner)));
                     bus.gnt_id   <= winner;
                     bus.hold_cnt <= '0;
                  end else begin
                     state         <= IDLE;
                     bus.gnt       <= '0;
                     bus.gnt_id    <= '0;
                     bus.gnt_valid <= 1'b0;
                     bus.hold_cnt  <= '0;
                  end
               end else if (bus.hold_cnt != '1) begin
                  // Saturates instead of wrapping when the hold is unlimited.
                  bus.hold_cnt <= bus.hold_cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter
//   Drives two arbiters from the same request stream: dut0 with a hold limit
//   of 4, dut1 unlimited with a 3-bit hold counter. Directed scenarios check
//   fixed expectations; the random scenario compares both against a
//   behavioural model that scans requesters in round-robin order.
module tb_rr_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_drv = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rr_grant_arbiter_if #(.N(8), .IDW(3), .CW(5)) if0 ();
   rr_grant_arbiter_if #(.N(8), .IDW(3), .CW(3)) if1 ();

   assign if0.req = req_drv;
   assign if1.req = req_drv;

   rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4), .CW(5)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(0), .CW(3)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   // ---------------- reference model ----------------
   int m_valid [2];
   int m_id    [2];
   int m_cnt   [2];
   int m_ptr   [2];
   int mh      [2] = '{4, 0};
   int cmax    [2] = '{31, 7};

   // First requester at or after 'start', walking round the ring.
   function automatic int first_from(input int start, input logic [7:0] q);
      for (int i = 0; i < 8; i++) begin
         if (q[(start + i) % 8]) return (start + i) % 8;
      end
      return -1;
   endfunction

   function automatic void model_update(input int d, input logic r, input logic [7:0] q);
      int w;
      bit rel;
      if (r) begin
         m_valid[d] = 0; m_id[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
      end else if (m_valid[d] == 0) begin
         w = first_from(m_ptr[d], q);
         if (w >= 0) begin
            m_valid[d] = 1; m_id[d] = w; m_cnt[d] = 0;
         end
      end else begin
         rel = (q[m_id[d]] == 1'b0) || (mh[d] != 0 && m_cnt[d] == mh[d] - 1);
         if (!rel) begin
            if (m_cnt[d] < cmax[d]) m_cnt[d]++;
         end else begin
            m_ptr[d] = (m_id[d] + 1) % 8;
            w = first_from(m_ptr[d], q);
            if (w >= 0) begin
               m_id[d] = w; m_cnt[d] = 0;
            end else begin
               m_valid[d] = 0; m_id[d] = 0; m_cnt[d] = 0;
            end
         end
      end
   endfunction

   function automatic logic [7:0] exp_gnt(input int d);
      logic [7:0] v;
      v = '0;
      if (m_valid[d] != 0) v[m_id[d]] = 1'b1;
      return v;
   endfunction

   // One clock: inputs applied 1 time unit after the previous edge, outputs
   // sampled 1 time unit after this edge.
   task automatic step(input logic r, input logic [7:0] q);
      rst     = r;
      req_drv = q;
      @(posedge clk);
      model_update(0, r, q);
      model_update(1, r, q);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      step(1'b1, 8'hFF);
      step(1'b1, 8'hFF);
      total++;
      if (if0.gnt !== 8'h00 || if0.gnt_valid !== 1'b0 || if0.gnt_id !== 3'd0 || if0.hold_cnt !== 5'd0) begin
         bad++;
         $display("FAIL reset_outputs got gnt=%h valid=%b id=%0d cnt=%0d want 00/0/0/0",
                  if0.gnt, if0.gnt_valid, if0.gnt_id, if0.hold_cnt);
      end
      step(1'b0, 8'hFF);
      total++;
      if (if0.gnt !== 8'h01 || if0.gnt_id !== 3'd0 || if0.gnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL first_grant got gnt=%h id=%0d valid=%b want 01/0/1",
                  if0.gnt, if0.gnt_id, if0.gnt_valid);
      end
   endtask

   // Continues straight on from test_reset: requester 0 is in its first cycle.
   task automatic test_fair_rotation;
      int e;
      for (int j = 1; j < 36; j++) begin
         step(1'b0, 8'hFF);
         e = (j / 4) % 8;
         total++;
         if (if0.gnt_id !== 3'(e) || if0.gnt_valid !== 1'b1 || if0.hold_cnt !== 5'(j % 4)) begin
            bad++;
            $display("FAIL rotation cycle %0d got id=%0d valid=%b cnt=%0d want %0d/1/%0d",
                     j, if0.gnt_id, if0.gnt_valid, if0.hold_cnt, e, j % 4);
         end
      end
   endtask

   task automatic test_release_by_drop;
      step(1'b1, 8'h00);
      step(1'b0, 8'b0010_0100);
      total++;
      if (if0.gnt_id !== 3'd2 || if0.gnt !== 8'h04) begin
         bad++;
         $display("FAIL drop_first got id=%0d gnt=%h want 2/04", if0.gnt_id, if0.gnt);
      end
      step(1'b0, 8'b0010_0100);
      step(1'b0, 8'b0010_0100);
      step(1'b0, 8'b0010_0000);
      total++;
      if (if0.gnt_id !== 3'd5 || if0.hold_cnt !== 5'd0 || if0.gnt !== 8'h20) begin
         bad++;
         $display("FAIL drop_handover got id=%0d cnt=%0d gnt=%h want 5/0/20",
                  if0.gnt_id, if0.hold_cnt, if0.gnt);
      end
   endtask

   // Continues from test_release_by_drop: requester 5 holds.
   task automatic test_wrap_idle;
      step(1'b0, 8'h00);
      total++;
      if (if0.gnt_valid !== 1'b0 || if0.gnt !== 8'h00 || if0.gnt_id !== 3'd0) begin
         bad++;
         $display("FAIL idle_after_release got valid=%b gnt=%h id=%0d want 0/00/0",
                  if0.gnt_valid, if0.gnt, if0.gnt_id);
      end
      step(1'b0, 8'b0100_0011);
      total++;
      if (if0.gnt_id !== 3'd6) begin
         bad++;
         $display("FAIL ptr_retained got id=%0d want 6", if0.gnt_id);
      end
      for (int j = 0; j < 3; j++) step(1'b0, 8'b0100_0011);
      step(1'b0, 8'b0100_0011);
      total++;
      if (if0.gnt_id !== 3'd0 || if0.hold_cnt !== 5'd0) begin
         bad++;
         $display("FAIL wrap_grant got id=%0d cnt=%0d want 0/0", if0.gnt_id, if0.hold_cnt);
      end
   endtask

   task automatic test_sole_preempt;
      step(1'b1, 8'h00);
      for (int j = 0; j < 10; j++) begin
         step(1'b0, 8'h80);
         total++;
         if (if0.gnt !== 8'h80 || if0.gnt_valid !== 1'b1 || if0.hold_cnt !== 5'(j % 4)) begin
            bad++;
            $display("FAIL sole_holder cycle %0d got gnt=%h valid=%b cnt=%0d want 80/1/%0d",
                     j, if0.gnt, if0.gnt_valid, if0.hold_cnt, j % 4);
         end
      end
   endtask

   task automatic test_reset_mid_grant;
      step(1'b1, 8'h00);
      step(1'b0, 8'h20);
      total++;
      if (if0.gnt_id !== 3'd5) begin
         bad++;
         $display("FAIL mid_setup got id=%0d want 5", if0.gnt_id);
      end
      step(1'b1, 8'h20);
      total++;
      if (if0.gnt !== 8'h00 || if0.gnt_id !== 3'd0 || if0.gnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got gnt=%h id=%0d valid=%b want 00/0/0",
                  if0.gnt, if0.gnt_id, if0.gnt_valid);
      end
      step(1'b0, 8'h60);
      total++;
      if (if0.gnt_id !== 3'd5 || if0.gnt !== 8'h20) begin
         bad++;
         $display("FAIL after_mid_reset got id=%0d gnt=%h want 5/20", if0.gnt_id, if0.gnt);
      end
   endtask

   // Unlimited hold: the counter climbs to its width limit and stays there.
   task automatic test_saturation;
      int e;
      step(1'b1, 8'h00);
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 8'h01);
         e = (j < 7) ? j : 7;
         total++;
         if (if1.hold_cnt !== 3'(e) || if1.gnt !== 8'h01 || if1.gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL saturate cycle %0d got cnt=%0d gnt=%h valid=%b want %0d/01/1",
                     j, if1.hold_cnt, if1.gnt, if1.gnt_valid, e);
         end
      end
   endtask

   task automatic test_random;
      logic [7:0] q;
      logic       r;
      q = 8'h00;
      step(1'b1, q);
      for (int j = 0; j < 400; j++) begin
         // Requests persist, each bit toggling occasionally, so both short
         // and long holds occur.
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) q[b] = ~q[b];
         end
         if ($urandom_range(0, 29) == 0) q = 8'h00;
         r = ($urandom_range(0, 59) == 0);
         step(r, q);
         total++;
         if (if0.gnt !== exp_gnt(0) || if0.gnt_id !== 3'(m_id[0]) ||
             if0.gnt_valid !== (m_valid[0] != 0) || if0.hold_cnt !== 5'(m_cnt[0])) begin
            bad++;
            $display("FAIL random0 cycle %0d req=%h got gnt=%h id=%0d v=%b cnt=%0d want %h/%0d/%0d/%0d",
                     j, q, if0.gnt, if0.gnt_id, if0.gnt_valid, if0.hold_cnt,
                     exp_gnt(0), m_id[0], m_valid[0], m_cnt[0]);
         end
         total++;
         if (if1.gnt !== exp_gnt(1) || if1.gnt_id !== 3'(m_id[1]) ||
             if1.gnt_valid !== (m_valid[1] != 0) || if1.hold_cnt !== 3'(m_cnt[1])) begin
            bad++;
            $display("FAIL random1 cycle %0d req=%h got gnt=%h id=%0d v=%b cnt=%0d want %h/%0d/%0d/%0d",
                     j, q, if1.gnt, if1.gnt_id, if1.gnt_valid, if1.hold_cnt,
                     exp_gnt(1), m_id[1], m_valid[1], m_cnt[1]);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_id[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
      end
      test_reset;
      test_fair_rotation;
      test_release_by_drop;
      test_wrap_idle;
      test_sole_preempt;
      test_reset_mid_grant;
      test_saturation;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters. It uses a fixed-priority encoder on a request vector rotated by a pointer. The block holds a registered one-hot grant plus an encoded grant index. A grant stays with its holder until that holder drops its request or a configurable hold limit expires, after which priority rotates past the holder. It sits in front of any shared datapath or bus that needs fair, starvation-free access.

Parameters:
N, 8, number of requesters; must be a power of 2, at least 2
IDW, 3, index width, equal to log2(N)
MAX_HOLD, 16, maximum consecutive grant cycles per holder; 0 means unlimited
CW, 5, hold counter width; must satisfy 2^CW > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  N  request vector; bit i is requester i
gnt  output  N  registered one-hot grant; all zeros when no grant
gnt_id  output  IDW  registered index of the current holder; 0 when gnt_valid=0
gnt_valid  output  1  registered; high while any grant is active
hold_cnt  output  CW  registered count of cycles the current holder has held the grant, starting at 0; debug/visibility

Behaviour:
- Reset: at any clk edge with rst=1:
  - gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0
  - internal ptr=0, state=IDLE
  - reset takes precedence over every other event, including mid-grant.
- Pick function (combinational):
  - Rotate req right by base.
  - Apply fixed priority, bit 0 highest.
  - winner = (enc + base) mod N.
  - any = |req.
  - Output is never X; with no request, enc=0 and any=0.
- State IDLE:
  - If any: pick with base=ptr. Next edge: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, state GRANT.
  - Otherwise remain in IDLE with outputs at zero.
  - Latency from req to gnt is 1 cycle.
- State GRANT, holder k:
  - release = (req[k]==0) OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
  - No release: hold_cnt increments; outputs unchanged.
  - On release: ptr <= (k+1) mod N, and pick with base=(k+1) mod N on the current req.
    - If any: grant the winner at the next edge with hold_cnt=0 (back-to-back, no idle cycle). k is lowest priority, so k is re-granted only if no other requester is active.
    - Otherwise: outputs go to zero next edge and state returns to IDLE.
- Requests that arrive or drop for non-holders during GRANT do not disturb the grant; they are sampled only at the release cycle.
- With MAX_HOLD=M>0, no grant lasts longer than M cycles. When all N request continuously, each requester gets M cycles in order k, k+1, …, wrapping from N-1 to 0.
- Wrap-around: ptr and winner arithmetic is modulo N; with IDW bits this is natural truncation.
- ptr is retained across IDLE periods and changes only on release or reset.
- hold_cnt saturates at its width limit when MAX_HOLD=0; it never wraps.
- Invariants:
  - gnt_valid equals |gnt.
  - gnt equals onehot(gnt_id) when valid.
  - gnt is at most one-hot at all times.

Decomposition:
- Shared package holds:
  - arb_state_t enum {IDLE, GRANT}
  - constants ARB_N=8, ARB_IDW=3, ARB_MAX_HOLD_DEF=16
  - a onehot(idx) function
- One sub-module, rot_prio_pick:
  - combinational rotate plus fixed-priority encode (bit 0 highest)
  - inputs req[N], base[IDW]
  - outputs winner[IDW], any
  - unit-testable on its own; instantiated once in rr_grant_arbiter.

Test Plan:
- Reset and first grant: hold rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_valid=0. One cycle after rst drops -> gnt=8'h01, gnt_id=0.
- Fair rotation: MAX_HOLD=4, req=8'hFF held steady -> gnt_id sequence 0,1,…,7,0, each value exactly 4 cycles, gnt_valid continuously 1.
- Release by drop: req=8'b0010_0100 -> gnt_id=2. Drop req[2] after 3 grant cycles -> next cycle gnt_id=5, hold_cnt=0.
- Sole requester preempt: MAX_HOLD=4, req=8'h80 for 10 cycles -> gnt=8'h80 throughout, hold_cnt sequence 0,1,2,3,0,1,2,3,0,1, gnt_valid never drops.
- Wrap and idle: after a grant to 5 is released with req=0 -> gnt_valid=0 next cycle and ptr stays 6. Then req=8'b0100_0011 -> gnt_id=6; on release -> gnt_id=0.
- Reset mid-grant: holder 5, assert rst for 1 cycle -> next edge gnt=0, gnt_id=0. Release rst with req=8'h60 -> gnt_id=5, since ptr=0 and the first set bit from 0 is 5.
